adaptive_peak_detector: RTL and testbench

Parametrised successor to the single-threshold heart-rate peak detector. It accepts a qualified stream of signed filtered samples and derives an adaptive threshold from the maximum of the previous tumbling window. It finds each supra-threshold excursion, reports one peak per excursion with its amplitude and its inter-peak interval in samples, and then enforces a refractory period. It sits between the signal transform stage and the BPM calculator.

---
 rtl/adaptive_peak_detector.sv | 179 +++++++++++++++++
 tb/tb_adaptive_peak_detector.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/adaptive_peak_detector.sv
// Adaptive-threshold peak detector: tumbling-window max sets the threshold,
// one peak per supra-threshold excursion, then a refractory hold-off.
module adaptive_peak_detector #(
  parameter int DATA_W     = 13,
  parameter int WIN_LOG2   = 8,
  parameter int THR_SHIFT  = 1,
  parameter int THR_OFFSET = 50,
  parameter int REFRACT    = 64,
  parameter int INT_W      = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     sample_valid,
  input  logic signed [DATA_W-1:0] sample_in,
  output logic                     peak_valid,
  output logic signed [DATA_W-1:0] peak_value,
  output logic        [INT_W-1:0]  peak_interval,
  output logic signed [DATA_W-1:0] window_max,
  output logic signed [DATA_W-1:0] threshold
);

  typedef enum logic [1:0] {
    IDLE,
    ABOVE,
    REFR
  } state_t;

  localparam int RW = (REFRACT > 1) ? $clog2(REFRACT) : 1;
  localparam int RL = (REFRACT > 0) ? REFRACT - 1 : 0;
  localparam logic [RW-1:0] RLAST = RW'(RL);

  localparam int OMAX = 2 ** (DATA_W - 1) - 1;
  localparam int OMIN = -(2 ** (DATA_W - 1));
  localparam int OFF_C = (THR_OFFSET > OMAX) ? OMAX :
                         (THR_OFFSET < OMIN) ? OMIN : THR_OFFSET;
  localparam logic signed [DATA_W:0] OFF_W = (DATA_W + 1)'(OFF_C);
  localparam logic signed [DATA_W-1:0] THR_RST = DATA_W'(OFF_C);
  localparam logic signed [DATA_W:0] SMAX = {2'b00, {(DATA_W-1){1'b1}}};
  localparam logic signed [DATA_W:0] SMIN = {2'b11, {(DATA_W-1){1'b0}}};

  function automatic logic signed [DATA_W-1:0] sat(
    input logic signed [DATA_W:0] x
  );
    if (x > SMAX) return SMAX[DATA_W-1:0];
    if (x < SMIN) return SMIN[DATA_W-1:0];
    return x[DATA_W-1:0];
  endfunction

  function automatic logic [INT_W-1:0] inc(input logic [INT_W-1:0] x);
    return (x == '1) ? x : x + INT_W'(1);
  endfunction

  state_t state_q, state_d;
  logic [WIN_LOG2-1:0] win_cnt_q, win_cnt_d;
  logic signed [DATA_W-1:0] run_max_q, run_max_d;
  logic signed [DATA_W-1:0] wmax_q, wmax_d;
  logic signed [DATA_W-1:0] thr_q, thr_d;
  logic signed [DATA_W-1:0] cand_q, cand_d;
  logic signed [DATA_W-1:0] pval_q, pval_d;
  logic [INT_W-1:0] int_cnt_q, int_cnt_d;
  logic [INT_W-1:0] cand_int_q, cand_int_d;
  logic [INT_W-1:0] since_q, since_d;
  logic [INT_W-1:0] pint_q, pint_d;
  logic [RW-1:0] refr_q, refr_d;
  logic pv_q, pv_d;

  logic above;
  logic signed [DATA_W-1:0] wm_new;
  logic signed [DATA_W:0] wm_ext;

  always_comb begin
    state_d    = state_q;
    win_cnt_d  = win_cnt_q;
    run_max_d  = run_max_q;
    wmax_d     = wmax_q;
    thr_d      = thr_q;
    cand_d     = cand_q;
    pval_d     = pval_q;
    int_cnt_d  = int_cnt_q;
    cand_int_d = cand_int_q;
    since_d    = since_q;
    pint_d     = pint_q;
    refr_d     = refr_q;
    pv_d       = 1'b0;
    above      = sample_in > thr_q;
    wm_new     = (sample_in > run_max_q) ? sample_in : run_max_q;
    wm_ext     = {wm_new[DATA_W-1], wm_new};

    if (sample_valid) begin
      int_cnt_d = inc(int_cnt_q);
      since_d   = inc(since_q);
      win_cnt_d = win_cnt_q + WIN_LOG2'(1);

      // closing sample still compares against the old threshold
      if (win_cnt_q == '1) begin
        wmax_d    = wm_new;
        run_max_d = '0;
        thr_d     = sat((wm_ext >>> THR_SHIFT) + OFF_W);
      end else begin
        run_max_d = wm_new;
      end

      unique case (state_q)
        IDLE: begin
          if (above) begin
            state_d    = ABOVE;
            cand_d     = sample_in;
            cand_int_d = int_cnt_q;
            since_d    = INT_W'(1);
          end
        end
        ABOVE: begin
          if (above) begin
            if (sample_in > cand_q) begin
              cand_d     = sample_in;
              cand_int_d = int_cnt_q;
              since_d    = INT_W'(1);
            end
          end else begin
            pv_d      = 1'b1;
            pval_d    = cand_q;
            pint_d    = cand_int_q;
            int_cnt_d = inc(since_q);
            refr_d    = '0;
            state_d   = (REFRACT == 0) ? IDLE : REFR;
          end
        end
        REFR: begin
          if (refr_q == RLAST) begin
            refr_d  = '0;
            state_d = IDLE;
          end else begin
            refr_d = refr_q + RW'(1);
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      win_cnt_q  <= '0;
      run_max_q  <= '0;
      wmax_q     <= '0;
      thr_q      <= THR_RST;
      cand_q     <= '0;
      pval_q     <= '0;
      int_cnt_q  <= '1;
      cand_int_q <= '0;
      since_q    <= '0;
      pint_q     <= '0;
      refr_q     <= '0;
      pv_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      win_cnt_q  <= win_cnt_d;
      run_max_q  <= run_max_d;
      wmax_q     <= wmax_d;
      thr_q      <= thr_d;
      cand_q     <= cand_d;
      pval_q     <= pval_d;
      int_cnt_q  <= int_cnt_d;
      cand_int_q <= cand_int_d;
      since_q    <= since_d;
      pint_q     <= pint_d;
      refr_q     <= refr_d;
      pv_q       <= pv_d;
    end
  end

  assign peak_valid    = pv_q;
  assign peak_value    = pval_q;
  assign peak_interval = pint_q;
  assign window_max    = wmax_q;
  assign threshold     = thr_q;

endmodule

// File: tb/tb_adaptive_peak_detector.sv
// Directed bench for adaptive_peak_detector with default parameters.
module tb_adaptive_peak_detector;

  logic clk = 1'b0;
  logic rst;
  logic sample_valid;
  logic signed [12:0] sample_in;
  logic peak_valid;
  logic signed [12:0] peak_value;
  logic [15:0] peak_interval;
  logic signed [12:0] window_max;
  logic signed [12:0] threshold;

  adaptive_peak_detector dut (
    .clk          (clk),
    .rst          (rst),
    .sample_valid (sample_valid),
    .sample_in    (sample_in),
    .peak_valid   (peak_valid),
    .peak_value   (peak_value),
    .peak_interval(peak_interval),
    .window_max   (window_max),
    .threshold    (threshold)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  bit gaps = 1'b0;
  logic signed [12:0] pk_val[$];
  int pk_int[$];

  always @(negedge clk) begin
    if (peak_valid === 1'b1) begin
      pk_val.push_back(peak_value);
      pk_int.push_back(int'(peak_interval));
    end
  end

  task automatic check(string tag, longint obs, longint exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", tag, obs, exp);
    end
  endtask

  task automatic idle(int n);
    sample_valid = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push(int v);
    if (gaps) begin
      repeat ($urandom_range(0, 1)) begin
        sample_valid = 1'b0;
        sample_in = 13'($urandom);
        @(posedge clk);
        #1;
      end
    end
    sample_valid = 1'b1;
    sample_in = 13'(v);
    @(posedge clk);
    #1;
    sample_valid = 1'b0;
  endtask

  task automatic pushn(int v, int n);
    repeat (n) push(v);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    sample_valid = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    pk_val.delete();
    pk_int.delete();
  endtask

  function automatic longint pv_at(int i);
    return (pk_val.size() > i) ? longint'(pk_val[i]) : -99999;
  endfunction

  function automatic longint pi_at(int i);
    return (pk_int.size() > i) ? longint'(pk_int[i]) : -99999;
  endfunction

  task automatic run3(string p);
    int v;
    do_reset();
    for (int i = 0; i < 121; i++) begin
      case (i)
        8: v = 60;
        9: v = 100;
        10: v = 150;
        11: v = 90;
        12: v = 20;
        108: v = 70;
        109: v = 140;
        110: v = 180;
        111: v = 100;
        112: v = 10;
        default: v = 0;
      endcase
      push(v);
    end
    idle(2);
    check({p, "_npk"}, pk_val.size(), 2);
    check({p, "_v0"}, pv_at(0), 150);
    check({p, "_i0"}, pi_at(0), 65535);
    check({p, "_v1"}, pv_at(1), 180);
    check({p, "_i1"}, pi_at(1), 100);
    check({p, "_thr"}, threshold, 50);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int v;
    rst = 1'b1;
    sample_valid = 1'b0;
    sample_in = '0;
    @(posedge clk);
    #1;

    // reset state and quiet idle
    do_reset();
    check("rst_thr", threshold, 50);
    check("rst_wm", window_max, 0);
    check("rst_pv", peak_valid, 0);
    check("rst_pval", peak_value, 0);
    check("rst_pint", peak_interval, 0);
    idle(10);
    check("idle_npk", pk_val.size(), 0);

    // single excursion, first peak after reset
    do_reset();
    push(0);
    push(0);
    push(60);
    push(120);
    push(80);
    check("t2_early", pk_val.size(), 0);
    push(40);
    check("t2_pv", peak_valid, 1);
    check("t2_val", peak_value, 120);
    check("t2_int", peak_interval, 65535);
    idle(1);
    check("t2_pulse", peak_valid, 0);
    check("t2_npk", pk_val.size(), 1);
    check("t2_hold", peak_value, 120);

    // two pulses, interval 100
    gaps = 1'b0;
    run3("t3");

    // refractory suppression
    do_reset();
    for (int i = 0; i < 91; i++) begin
      case (i)
        5: v = 100;
        26: v = 200;
        86: v = 200;
        default: v = 0;
      endcase
      push(v);
      if (i == 30) check("t4_refr", pk_val.size(), 1);
    end
    idle(2);
    check("t4_npk", pk_val.size(), 2);
    check("t4_v1", pv_at(1), 200);
    check("t4_i1", pi_at(1), 81);

    // refractory end boundary
    do_reset();
    for (int i = 0; i < 76; i++) begin
      case (i)
        5: v = 100;
        70: v = 300;
        71: v = 210;
        default: v = 0;
      endcase
      push(v);
    end
    idle(2);
    check("t4b_npk", pk_val.size(), 2);
    check("t4b_v1", pv_at(1), 210);
    check("t4b_i1", pi_at(1), 66);

    // window max drives threshold
    do_reset();
    for (int i = 0; i < 255; i++) push((i == 100) ? 1000 : 0);
    check("t5_thr_old", threshold, 50);
    check("t5_wm_old", window_max, 0);
    push(0);
    check("t5_wm", window_max, 1000);
    check("t5_thr", threshold, 550);
    for (int i = 256; i < 331; i++) begin
      case (i)
        300: v = 500;
        320: v = 600;
        default: v = 0;
      endcase
      push(v);
    end
    idle(2);
    check("t5_npk", pk_val.size(), 2);
    check("t5_v0", pv_at(0), 1000);
    check("t5_v1", pv_at(1), 600);
    check("t5_i1", pi_at(1), 220);

    // negative window floors at 0; closing sample uses old threshold
    do_reset();
    pushn(-100, 256);
    check("t5b_wm0", window_max, 0);
    check("t5b_thr0", threshold, 50);
    pushn(-100, 255);
    push(60);
    check("t5b_wm", window_max, 60);
    check("t5b_thr", threshold, 80);
    check("t5b_nopk", peak_valid, 0);
    push(70);
    check("t5b_pv", peak_valid, 1);
    check("t5b_val", peak_value, 60);
    check("t5b_int", peak_interval, 65535);

    // gaps in sample_valid
    gaps = 1'b1;
    run3("t6g");
    gaps = 1'b0;

    // reset mid-excursion
    do_reset();
    push(80);
    push(0);
    pushn(0, 64);
    push(100);
    push(150);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("t6r_pv", peak_valid, 0);
    check("t6r_pval", peak_value, 0);
    check("t6r_pint", peak_interval, 0);
    check("t6r_wm", window_max, 0);
    check("t6r_thr", threshold, 50);
    pushn(0, 3);
    idle(1);
    check("t6r_npk", pk_val.size(), 1);
    push(90);
    push(0);
    check("t6r_pv2", peak_valid, 1);
    check("t6r_val2", peak_value, 90);
    check("t6r_int2", peak_interval, 65535);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
